// File: rtl/tow_pkg.sv
// Shared Tug-of-War definitions.
// Holds the default synchroniser depth and debounce length for the player buttons, plus the
// channel-index width helper that sizes first_id here and in the game-control FSM.
package tow_pkg;

    localparam int unsigned TOW_SYNC_STAGES     = 2;
    localparam int unsigned TOW_DEBOUNCE_CYCLES = 4;

    // Width of a channel index. It is at least 1 so that a single-channel build still has a port.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/press_conditioner.sv
// Single-channel button conditioner: synchroniser, debounce counter and rising-edge detector.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   trigger   - raw asynchronous button level
//   level     - debounced level (registered)
//   pulse     - one-cycle press strobe, registered together with level
//   rise      - press accepted on the coming edge; decoded from registers only
module press_conditioner
    import tow_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = TOW_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = TOW_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    output logic level,
    output logic pulse,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   s;
    logic                   accept;

    assign s      = sync[SYNC_STAGES-1];
    // The DEBOUNCE_CYCLES-th consecutive disagreeing sample commits the new level.
    assign accept = (s != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign rise   = accept && s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], trigger};
            pulse <= rise;
            if (s == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/press_latch.sv
// Multi-channel sticky press latch with first-press arbitration.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   trigger      - raw button levels, one per channel
//   clr          - synchronous clear of out and arbitration state
//   level        - debounced levels
//   pulse        - one-cycle press strobes
//   out          - sticky latched press flags
//   first_valid  - an arbitration winner is held
//   first_id     - lowest-index channel that pressed in the winning cycle
//   tie          - more than one channel pressed in the winning cycle
module press_latch
    import tow_pkg::*;
#(
    parameter int unsigned CHANNELS        = 2,
    parameter int unsigned SYNC_STAGES     = TOW_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = TOW_DEBOUNCE_CYCLES,
    parameter int unsigned FIRST_WINS      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           trigger,
    input  logic                          clr,
    output logic [CHANNELS-1:0]           level,
    output logic [CHANNELS-1:0]           pulse,
    output logic [CHANNELS-1:0]           out,
    output logic                          first_valid,
    output logic [id_width(CHANNELS)-1:0] first_id,
    output logic                          tie
);

    localparam int unsigned ID_W = id_width(CHANNELS);

    logic [CHANNELS-1:0] rise;
    logic [ID_W-1:0]     win_id;
    logic                found;
    logic                multi;
    logic                any_rise;
    logic                locked;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        press_conditioner #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cond (
            .clk     (clk),
            .rst     (rst),
            .trigger (trigger[i]),
            .level   (level[i]),
            .pulse   (pulse[i]),
            .rise    (rise[i])
        );
    end

    // Priority encoder: lowest-index pressing channel wins.
    always_comb begin
        win_id = '0;
        found  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rise[i] && !found) begin
                win_id = ID_W'(i);
                found  = 1'b1;
            end
        end
    end

    assign any_rise = |rise;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi    = |(rise & (rise - CHANNELS'(1)));
    assign locked   = (FIRST_WINS != 0) && first_valid;

    always_ff @(posedge clk) begin
        // clr shares the reset branch so it beats any press in the same cycle.
        if (rst || clr) begin
            out         <= '0;
            first_valid <= 1'b0;
            first_id    <= '0;
            tie         <= 1'b0;
        end else begin
            if (!locked) begin
                out <= out | rise;
            end
            if (any_rise && !first_valid) begin
                first_valid <= 1'b1;
                first_id    <= win_id;
                tie         <= multi;
            end
        end
    end

endmodule

// File: tb/tb_press_latch.sv
module tb_press_latch;
    import tow_pkg::*;

    localparam int CH = 2;
    localparam int SS = 2;
    localparam int DC = 4;
    localparam int HL = SS + DC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [1:0] trigger = 2'b00;

    logic [1:0] lv_a, pu_a, out_a, lv_b, pu_b, out_b;
    logic       fv_a, fv_b, tie_a, tie_b;
    logic [0:0] id_a, id_b;

    press_latch #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .FIRST_WINS(1)
    ) dut_fw (
        .clk(clk), .rst(rst), .trigger(trigger), .clr(clr),
        .level(lv_a), .pulse(pu_a), .out(out_a),
        .first_valid(fv_a), .first_id(id_a), .tie(tie_a)
    );

    press_latch #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .FIRST_WINS(0)
    ) dut_ind (
        .clk(clk), .rst(rst), .trigger(trigger), .clr(clr),
        .level(lv_b), .pulse(pu_b), .out(out_b),
        .first_valid(fv_b), .first_id(id_b), .tie(tie_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: trigger sample history per channel; index 0 is the newest sample.
    logic       hist [CH][HL];
    logic [1:0] m_level = '0;
    logic [1:0] m_pulse = '0;
    logic [1:0] m_out [2];
    logic       m_fv  [2];
    logic       m_id  [2];
    logic       m_tie [2];

    task automatic model_reset();
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < HL; k++) hist[c][k] = 1'b0;
        m_level = '0;
        m_pulse = '0;
        for (int f = 0; f < 2; f++) begin
            m_out[f] = '0; m_fv[f] = 1'b0; m_id[f] = 1'b0; m_tie[f] = 1'b0;
        end
    endtask

    // One clock edge of the model, using inputs as seen at that edge.
    // Level flips when the DC synced samples ending SS edges ago all disagree with it.
    task automatic model_step();
        logic [1:0] rise;
        logic       flip;
        logic       old_fv;
        for (int c = 0; c < CH; c++) begin
            for (int k = HL - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = trigger[c];
        end
        if (rst) begin
            model_reset();
            return;
        end
        rise = 2'b00;
        for (int c = 0; c < CH; c++) begin
            flip = 1'b1;
            for (int j = 0; j < DC; j++)
                if (hist[c][SS+j] == m_level[c]) flip = 1'b0;
            if (flip) begin
                rise[c]    = ~m_level[c];
                m_level[c] = ~m_level[c];
            end
        end
        m_pulse = rise;
        for (int f = 0; f < 2; f++) begin
            if (clr) begin
                m_out[f] = '0; m_fv[f] = 1'b0; m_id[f] = 1'b0; m_tie[f] = 1'b0;
            end else begin
                old_fv = m_fv[f];
                if (!(f == 1 && old_fv)) m_out[f] = m_out[f] | rise;
                if (rise != 2'b00 && !old_fv) begin
                    m_fv[f]  = 1'b1;
                    m_id[f]  = rise[0] ? 1'b0 : 1'b1;
                    m_tie[f] = (rise == 2'b11);
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model_fw", 16'({lv_a, pu_a, out_a, fv_a, id_a, tie_a}),
            16'({m_level, m_pulse, m_out[1], m_fv[1], m_id[1], m_tie[1]}));
        chk("model_ind", 16'({lv_b, pu_b, out_b, fv_b, id_b, tie_b}),
            16'({m_level, m_pulse, m_out[0], m_fv[0], m_id[0], m_tie[0]}));
    endtask

    typedef struct {
        logic       rst;
        logic       clr;
        logic [1:0] trig;
        logic [1:0] lvl;
        logic [1:0] pul;
        logic [1:0] out;
        logic       fv;
        logic       id;
        logic       tie;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic c, logic [1:0] t, logic [1:0] l, logic [1:0] p,
                                logic [1:0] o, logic fv, logic id, logic ti);
        vec_t v;
        v.rst = r; v.clr = c; v.trig = t; v.lvl = l; v.pul = p;
        v.out = o; v.fv = fv; v.id = id; v.tie = ti;
        return v;
    endfunction

    int hold [CH];

    initial begin
        model_reset();

        // Table: press on channel 0 from edge 1, then a 3-cycle glitch on channel 1.
        tv.push_back(mk(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
        tv.push_back(mk(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
        for (int e = 1; e <= 5; e++) tv.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0));
        tv.push_back(mk(0, 0, 2'b01, 2'b01, 2'b01, 2'b01, 1, 0, 0));
        tv.push_back(mk(0, 0, 2'b01, 2'b01, 2'b00, 2'b01, 1, 0, 0));
        for (int e = 0; e < 3; e++) tv.push_back(mk(0, 0, 2'b11, 2'b01, 2'b00, 2'b01, 1, 0, 0));
        for (int e = 0; e < 8; e++) tv.push_back(mk(0, 0, 2'b01, 2'b01, 2'b00, 2'b01, 1, 0, 0));

        foreach (tv[i]) begin
            rst = tv[i].rst; clr = tv[i].clr; trigger = tv[i].trig;
            tick();
            chk($sformatf("table_%0d", i), 16'({lv_a, pu_a, out_a, fv_a, id_a, tie_a}),
                16'({tv[i].lvl, tv[i].pul, tv[i].out, tv[i].fv, tv[i].id, tv[i].tie}));
        end

        // Simultaneous press, then re-press of channel 0 while locked.
        rst = 1; trigger = 2'b00; tick(); rst = 0;
        trigger = 2'b11;
        repeat (6) tick();
        chk("sim_out", 16'(out_a), 16'(2'b11));
        chk("sim_id_tie", 16'({fv_a, id_a, tie_a}), 16'(3'b101));
        trigger = 2'b00;
        repeat (6) tick();
        chk("sim_release", 16'(lv_a), 16'(2'b00));
        trigger = 2'b01;
        repeat (6) tick();
        chk("repress_pulse", 16'(pu_a), 16'(2'b01));
        chk("repress_hold", 16'({out_a, fv_a, id_a, tie_a}), 16'(5'b11101));

        // Channel 1 leads channel 0 by 3 cycles.
        rst = 1; trigger = 2'b00; tick(); rst = 0;
        trigger = 2'b10;
        repeat (3) tick();
        trigger = 2'b11;
        repeat (3) tick();
        chk("lead_fw_first", 16'({out_a, id_a}), 16'(3'b101));
        chk("lead_ind_first", 16'({out_b, id_b}), 16'(3'b101));
        repeat (3) tick();
        chk("lead_fw_out", 16'({out_a, fv_a, id_a, tie_a}), 16'(5'b10110));
        chk("lead_ind_out", 16'({out_b, fv_b, id_b, tie_b}), 16'(5'b11110));

        // clr on the press edge, held button, then release and re-press.
        rst = 1; trigger = 2'b00; tick(); rst = 0;
        trigger = 2'b01;
        repeat (5) tick();
        clr = 1;
        tick();
        chk("clr_edge", 16'({pu_a, out_a, fv_a}), 16'(5'b01000));
        clr = 0;
        repeat (8) tick();
        chk("clr_no_relatch", 16'({lv_a, out_a, fv_a}), 16'(5'b01000));
        trigger = 2'b00;
        repeat (6) tick();
        chk("clr_release", 16'(lv_a), 16'(2'b00));
        trigger = 2'b01;
        repeat (5) tick();
        chk("clr_repress_early", 16'(out_a), 16'(2'b00));
        tick();
        chk("clr_repress", 16'({out_a, fv_a}), 16'(3'b011));

        // Reset with cnt at 2 and trigger still high.
        rst = 1; trigger = 2'b00; tick(); rst = 0;
        trigger = 2'b01;
        repeat (4) tick();
        rst = 1;
        tick();
        chk("rst_mid_all0", 16'({lv_a, pu_a, out_a, fv_a, id_a, tie_a}), 16'(0));
        rst = 0;
        repeat (5) tick();
        chk("rst_relatch_early", 16'(out_a), 16'(2'b00));
        tick();
        chk("rst_relatch", 16'({out_a, pu_a}), 16'(4'b0101));

        // Random bursts with occasional clr and reset.
        rst = 1; trigger = 2'b00; tick(); rst = 0;
        for (int c = 0; c < CH; c++) hold[c] = 0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    trigger[c] = ~trigger[c];
                    hold[c] = $urandom_range(1, 14);
                end else begin
                    hold[c]--;
                end
            end
            clr = ($urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 249) == 0);
            tick();
        end
        rst = 0; clr = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/press_latch.md
# press_latch

Multi-channel, parametrised successor to the single-bit set/clear latch used for the Tug-of-War player inputs. Each channel synchronises and debounces a raw button `trigger` and detects its rising edge. The edge sets a sticky `out` bit that holds until `clr`. The block also arbitrates which channel pressed first, with optional first-wins lockout. It sits between the board push-buttons and the game-control FSM, which reads `first_id` to award a pull and pulses `clr` to re-arm.

## Interface
Parameters:
- `CHANNELS`, 2: number of independent input channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required to accept a level change (≥1).
- `FIRST_WINS`, 1: 1 = only the first press(es) latch until `clr`; 0 = every channel latches independently.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `trigger`, in, CHANNELS: raw asynchronous button levels.
- `clr`, in, 1: synchronous clear of latched/arbitration state.
- `level`, out, CHANNELS: debounced input level.
- `pulse`, out, CHANNELS: one-cycle press strobe per channel.
- `out`, out, CHANNELS: sticky latched press flags.
- `first_valid`, out, 1: an arbitration winner is held.
- `first_id`, out, max(1,$clog2(CHANNELS)): index of the winning channel.
- `tie`, out, 1: more than one channel won in the same cycle.

## Operation
- Per channel: `trigger` → SYNC_STAGES flop chain → synced level `s`.
- Debounce: counter `cnt` (width $clog2(DEBOUNCE_CYCLES)+1).
  - `s == level`: `cnt` ← 0.
  - `s != level` and `cnt == DEBOUNCE_CYCLES-1`: `level` ← `s`, `cnt` ← 0.
  - Otherwise `cnt` increments.
  - Result: any excursion of `s` shorter than DEBOUNCE_CYCLES cycles is discarded.
- Press event: the cycle `level` transitions 0→1 registers `pulse[i]` = 1 for exactly one cycle. Falling transitions generate nothing.
- Latch set: on a press event, `out[i]` ← 1, unless blocked:
  - FIRST_WINS=1 and `first_valid` already 1: blocked. `pulse` still fires.
  - `clr` asserted in the same cycle: blocked.
- Arbitration: in the first cycle with ≥1 accepted press while `first_valid`=0:
  - `first_valid` ← 1.
  - `first_id` ← lowest-index pressing channel.
  - `tie` ← 1 if more than one channel pressed that cycle.
  - In FIRST_WINS=1 every channel pressing in that cycle sets its `out`. Later presses are ignored until `clr`.
  - `first_id` and `tie` are held until `clr` or `rst`.
- `clr`: `out`, `first_valid`, `first_id` and `tie` all ← 0; clear has priority over any same-cycle set. `clr` does not touch the synchroniser, `cnt`, `level` or `pulse`. A button still held through `clr` therefore does not re-latch; a new press requires release (debounced) and a new press.
- `rst`: every register ← 0.
  - Outputs after reset: `level`, `pulse` and `out` are all 0; `first_valid`=0, `first_id`=0, `tie`=0.
  - A trigger held high through reset is treated as a fresh press and latches a full latency L after reset deasserts.
  - Reset mid-debounce discards the partial count.

## Timing
- Press latency L = SYNC_STAGES + DEBOUNCE_CYCLES clock edges. Counting the first edge sampling `trigger`=1 as edge 1, `level`, `pulse`, `out` and `first_*` update on edge L (6 with defaults).
- Release latency is identical: `level` falls L edges after `trigger` falls.
- Minimum re-press interval: release L plus press L.
- `pulse` width: exactly 1 cycle. `out` is level-held.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Shared package `tow_pkg` holds the default values `TOW_SYNC_STAGES=2` and `TOW_DEBOUNCE_CYCLES=4`, plus the channel-index width function (clog2 clamped to ≥1). The game-control FSM uses the same function to size its `first_id` input.
- Sub-module `press_conditioner`, parameterised by SYNC_STAGES and DEBOUNCE_CYCLES. It contains the synchroniser, debounce counter and edge detector, and emits `level` and `pulse` for one channel. It is instantiated CHANNELS times via generate.
- Top level holds the `out` register, the priority encoder and the arbitration registers.

## Test plan
- Defaults, `trigger[0]` held high from edge 1 → `pulse[0]`=1 on edge 6 only; `out`=2'b01, `first_valid`=1, `first_id`=0, `tie`=0 from edge 6.
- 3-cycle glitch on `trigger[1]` (DEBOUNCE_CYCLES=4) → `level`, `pulse` and `out` stay 0 throughout.
- Both triggers rise on the same edge, FIRST_WINS=1 → `out`=2'b11, `first_id`=0, `tie`=1. Then `trigger[0]` re-pressed after release → `pulse[0]` fires, `out` and `first_id` unchanged.
- Channel 1 presses 3 cycles before channel 0, FIRST_WINS=1 → `out`=2'b10, `first_id`=1. Same sequence with FIRST_WINS=0 → `out`=2'b11, `first_id`=1.
- `clr` asserted on the same edge as a press on channel 0 → `pulse[0]`=1, `out`=0, `first_valid`=0. Held button gives no relatch afterwards; release then re-press → latches after L.
- `rst` asserted mid-debounce (`cnt`=2) with `trigger` still high → all outputs 0 next cycle; `out[0]` sets exactly L edges after `rst` deasserts.
